// File: rtl/trace_scanout.sv
// Read side of the oscilloscope frame buffer: VGA raster timing, sample fetch and trace render.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pix_en_i       pixel tick, single-clk pulse, at least 2 clk apart
//   rd_addr_o      sample buffer read address (display column)
//   rd_data_i      sample row, valid one clk after rd_addr_o; V_ACTIVE/2 is zero volts
//   frame_start_o  single-clk pulse when the raster wraps to (0,0)
//   hsync_o        horizontal sync, active low
//   vsync_o        vertical sync, active low
//   red_o          pixel red
//   green_o        pixel green
//   blue_o         pixel blue
//
// Pipeline: stage 0 registers raster flags and the read address on pix_en, stage 1 captures the
// sample one clk later, and the colour/sync register updates on the following pix_en. Sync and
// colour therefore share the same two-tick latency.
module trace_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PLOT_W   = 480,
  parameter int unsigned GRID_DIV = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en_i,
  output logic [8:0] rd_addr_o,
  input  logic [9:0] rd_data_i,
  output logic       frame_start_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast    = 10'(HTotal - 1);
  localparam logic [9:0] VLast    = 10'(VTotal - 1);
  localparam logic [9:0] HAct     = 10'(H_ACTIVE);
  localparam logic [9:0] VAct     = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] PlotW    = 10'(PLOT_W);
  localparam logic [8:0] AddrLast = 9'(PLOT_W - 1);
  localparam logic [9:0] AxisX    = 10'(PLOT_W / 2);
  localparam logic [9:0] AxisY    = 10'(V_ACTIVE / 2);
  localparam logic [9:0] RowLast  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] GridLast = 10'(GRID_DIV - 1);

  // ---------------------------------------------------------------------------------------------
  // Raster and grid phase counters
  // ---------------------------------------------------------------------------------------------
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] gx_q, gx_d;
  logic [9:0] gy_q, gy_d;
  logic       h_last, v_last;

  assign h_last = (h_cnt_q == HLast);
  assign v_last = (v_cnt_q == VLast);

  // gx/gy track h/v modulo GRID_DIV incrementally so no divider is needed.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    if (pix_en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        gx_d    = '0;
        if (v_last) begin
          v_cnt_d = '0;
          gy_d    = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
          gy_d    = (gy_q == GridLast) ? '0 : gy_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        gx_d    = (gx_q == GridLast) ? '0 : gx_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 0: read address and per-pixel flags, captured on pix_en
  // ---------------------------------------------------------------------------------------------
  logic       s0_vld_q;
  logic [9:0] s0_y_q;
  logic       s0_active_q, s0_plot_q, s0_col0_q;
  logic       s0_hs_q, s0_vs_q, s0_axis_q, s0_grid_q;
  logic [8:0] rd_addr_q;

  // Stage 1: strobe one clk after pix_en, when rd_data_i holds the fetched sample.
  logic       s1_stb_q;
  logic [9:0] cur_row_q, cur_row_d;

  assign cur_row_d = s1_stb_q ? rd_data_i : cur_row_q;

  // ---------------------------------------------------------------------------------------------
  // Trace hit detection and output stage
  // ---------------------------------------------------------------------------------------------
  logic       prev_vld_q, prev_vld_d;
  logic [9:0] prev_row_q, prev_row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [3:0] red_q, red_d;
  logic [3:0] green_q, green_d;
  logic [3:0] blue_q, blue_d;
  logic       frame_start_d;

  logic       cur_vld, prev_ok, hit;
  logic [9:0] cur_scr, span_lo, span_hi;

  always_comb begin
    cur_vld = (cur_row_q < VAct);
    cur_scr = RowLast - cur_row_q;
    // Column 0 never connects to the last column of the previous line.
    prev_ok = prev_vld_q && !s0_col0_q;
    span_lo = cur_scr;
    span_hi = cur_scr;
    if (prev_ok) begin
      if (prev_row_q < cur_scr) begin
        span_lo = prev_row_q;
      end else begin
        span_hi = prev_row_q;
      end
    end
    hit = s0_plot_q && cur_vld && (s0_y_q >= span_lo) && (s0_y_q <= span_hi);
  end

  always_comb begin
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    prev_vld_d = prev_vld_q;
    prev_row_d = prev_row_q;
    if (pix_en_i && s0_vld_q) begin
      hsync_d = ~s0_hs_q;
      vsync_d = ~s0_vs_q;
      red_d   = 4'h0;
      green_d = 4'h0;
      blue_d  = 4'h0;
      if (s0_active_q && s0_plot_q) begin
        if (hit) begin
          green_d = 4'hF;
        end else if (s0_axis_q) begin
          red_d   = 4'h8;
          green_d = 4'h8;
          blue_d  = 4'h8;
        end else if (s0_grid_q) begin
          red_d   = 4'h4;
          green_d = 4'h4;
          blue_d  = 4'h4;
        end
      end
      prev_vld_d = cur_vld;
      prev_row_d = cur_scr;
    end
  end

  // The reset state is already (0,0), so the first frame after reset produces no pulse.
  assign frame_start_d = pix_en_i && h_last && v_last;

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      s0_vld_q    <= 1'b0;
      s0_y_q      <= '0;
      s0_active_q <= 1'b0;
      s0_plot_q   <= 1'b0;
      s0_col0_q   <= 1'b0;
      s0_hs_q     <= 1'b0;
      s0_vs_q     <= 1'b0;
      s0_axis_q   <= 1'b0;
      s0_grid_q   <= 1'b0;
      rd_addr_q   <= '0;
      s1_stb_q    <= 1'b0;
      cur_row_q   <= '0;
      prev_vld_q  <= 1'b0;
      prev_row_q  <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      frame_start_o <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s1_stb_q   <= pix_en_i;
      cur_row_q  <= cur_row_d;
      prev_vld_q <= prev_vld_d;
      prev_row_q <= prev_row_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      frame_start_o <= frame_start_d;
      if (pix_en_i) begin
        s0_vld_q    <= 1'b1;
        s0_y_q      <= v_cnt_q;
        s0_active_q <= (h_cnt_q < HAct) && (v_cnt_q < VAct);
        s0_plot_q   <= (h_cnt_q < PlotW);
        s0_col0_q   <= (h_cnt_q == 10'd0);
        s0_hs_q     <= (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
        s0_vs_q     <= (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);
        s0_axis_q   <= (h_cnt_q == AxisX) || (v_cnt_q == AxisY);
        s0_grid_q   <= (gx_q == 10'd0) || (gy_q == 10'd0);
        rd_addr_q   <= (h_cnt_q < PlotW) ? h_cnt_q[8:0] : AddrLast;
      end
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign red_o     = red_q;
  assign green_o   = green_q;
  assign blue_o    = blue_q;

endmodule

// File: tb/tb_trace_scanout.sv
// Bench for trace_scanout on a scaled-down raster (same structure, fewer pixels) so that several
// complete frames fit in a short run. Expected pixels are pushed to a queue as each pix_en tick
// is driven and popped when the DUT presents that pixel two ticks later.
module tb_trace_scanout;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 48;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int PW  = 48;
  localparam int GD  = 8;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int ZERO  = VA / 2;
  localparam int CLIPX = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       pe_d = 1'b0;
  logic [8:0] rd_addr;
  logic [9:0] rd_data;
  logic       frame_start, hsync, vsync;
  logic [3:0] red, green, blue;

  logic [9:0] mem [0:511];

  int n_chk = 0;
  int n_bad = 0;

  // Raster model and monitors
  int    bh = 0;
  int    bv = 0;
  int    fs_cnt = 0;
  int    hs_run = 0;
  int    vs_run = 0;
  int    post_ticks = 0;
  bit    hs_seen = 0;
  string cur_tag = "px";
  logic [13:0] sb_q [$];

  trace_scanout #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .PLOT_W   (PW),
    .GRID_DIV (GD)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_en_i      (pix_en),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .frame_start_o (frame_start),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue)
  );

  always #10 clk = ~clk;

  // Memory presents data only in the clk after the read address is issued; garbage otherwise.
  always @(posedge clk) pe_d <= pix_en;
  always_comb rd_data = pe_d ? mem[rd_addr] : 10'h3FF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, bh, bv, $time);
    end
  endtask

  function automatic logic [13:0] exp_px(input int x, input int y);
    logic       hs, vs, hit;
    logic [11:0] rgb;
    int cur, prv, cr, pr, lo, hi;
    hs  = !(x >= HA + HFP && x < HA + HFP + HSW);
    vs  = !(y >= VA + VFP && y < VA + VFP + VSW);
    rgb = 12'h000;
    if (x < HA && y < VA && x < PW) begin
      hit = 1'b0;
      cur = int'(mem[x]);
      if (cur < VA) begin
        cr = VA - 1 - cur;
        lo = cr;
        hi = cr;
        if (x > 0) begin
          prv = int'(mem[x-1]);
          if (prv < VA) begin
            pr = VA - 1 - prv;
            lo = (pr < cr) ? pr : cr;
            hi = (pr < cr) ? cr : pr;
          end
        end
        hit = (y >= lo) && (y <= hi);
      end
      if (hit) rgb = 12'h0F0;
      else if (x == PW / 2 || y == VA / 2) rgb = 12'h888;
      else if (x % GD == 0 || y % GD == 0) rgb = 12'h444;
    end
    return {hs, vs, rgb};
  endfunction

  task automatic fill(input int p);
    for (int i = 0; i < 512; i++) begin
      case (p)
        0:       mem[i] = 10'(ZERO);
        1:       mem[i] = (i % 2 == 1) ? 10'd30 : 10'd10;
        2:       mem[i] = (i == CLIPX) ? 10'd60 : 10'(ZERO);
        default: mem[i] = 10'($urandom_range(0, VA + 7));
      endcase
    end
  endtask

  task automatic do_tick();
    int          exp_addr;
    logic        wrap;
    logic [13:0] e;
    @(negedge clk);
    pix_en   = 1'b1;
    exp_addr = (bh < PW) ? bh : PW - 1;
    sb_q.push_back(exp_px(bh, bv));
    wrap = (bh == HT - 1) && (bv == VT - 1);
    if (bh == HT - 1) begin
      bh = 0;
      bv = (bv == VT - 1) ? 0 : bv + 1;
    end else begin
      bh = bh + 1;
    end
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    post_ticks++;
    check_eq("rd_addr", 32'(rd_addr), 32'(exp_addr));
    check_eq("frame_start", 32'(frame_start), 32'(wrap));
    if (frame_start === 1'b1) fs_cnt++;
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check_eq(cur_tag, 32'({hsync, vsync, red, green, blue}), 32'(e));
    end
    if (hsync === 1'b0) begin
      if (!hs_seen) begin
        hs_seen = 1;
        check_eq("hs_first", 32'(post_ticks), 32'(HA + HFP + 2));
      end
      hs_run++;
    end else if (hs_run != 0) begin
      check_eq("hs_width", 32'(hs_run), 32'(HSW));
      hs_run = 0;
    end
    if (vsync === 1'b0) begin
      vs_run++;
    end else if (vs_run != 0) begin
      check_eq("vs_width", 32'(vs_run), 32'(VSW * HT));
      vs_run = 0;
    end
    // Keep pix_en pulses at least 2 clk apart, sometimes 3.
    @(posedge clk);
    if ($urandom_range(0, 7) == 0) @(posedge clk);
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_sync"}, 32'({hsync, vsync}), 32'h3);
    check_eq({pfx, "_rgb"}, 32'({red, green, blue}), 32'h0);
    check_eq({pfx, "_fs"}, 32'(frame_start), 32'h0);
    check_eq({pfx, "_addr"}, 32'(rd_addr), 32'h0);
  endtask

  task automatic model_reset();
    bh         = 0;
    bv         = 0;
    fs_cnt     = 0;
    hs_run     = 0;
    vs_run     = 0;
    post_ticks = 0;
    hs_seen    = 0;
    sb_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(0);
    #35;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int p = 0; p < 4; p++) begin
      fill(p);
      case (p)
        0:       cur_tag = "px_flat";
        1:       cur_tag = "px_alt";
        2:       cur_tag = "px_clip";
        default: cur_tag = "px_rand";
      endcase
      for (int t = 0; t < HT * VT; t++) do_tick();
    end
    check_eq("fs_count", 32'(fs_cnt), 32'd4);

    // Reset in the middle of a visible line.
    fill(3);
    cur_tag = "px_prerst";
    for (int t = 0; t < HT * VT && !(bh == 30 && bv == 20); t++) do_tick();
    check_eq("rst_point", 32'(bv * HT + bh), 32'(20 * HT + 30));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset("post");

    cur_tag = "px_postrst";
    for (int t = 0; t < HT * VT + 8; t++) do_tick();
    check_eq("fs_after_rst", 32'(fs_cnt), 32'd1);
    check_eq("hs_seen", 32'(hs_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
